// File: rtl/l2_wb_pkg.sv
// Shared L2 geometry constants and the flush FSM state type used by the
// write-back buffer and its address CAM.
package l2_wb_pkg;

   localparam int L2_DATA_W     = 512;
   localparam int L2_LINE_OFF_W = 6;
   localparam int L2_ADDR_W     = 32 - L2_LINE_OFF_W;

   typedef enum logic [1:0] {
      NORMAL = 2'd0,
      FLUSH  = 2'd1,
      DONE   = 2'd2
   } flush_state_e;

endpackage

// File: rtl/l2_wb_addr_cam.sv
// DEPTH-entry line address compare: match is set when any valid entry holds
// cmp_addr. Entry addresses arrive flattened, entry i at [i*ADDR_W +: ADDR_W].
module l2_wb_addr_cam #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 26
) (
   input  logic [DEPTH*ADDR_W-1:0] entry_addr,
   input  logic [DEPTH-1:0]        entry_valid,
   input  logic [ADDR_W-1:0]       cmp_addr,
   output logic                    match
);

   always_comb begin
      // NOTE: default assigned first so no path through the loop infers a latch.
      match = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entry_valid[i] && (entry_addr[i*ADDR_W +: ADDR_W] == cmp_addr)) begin
            match = 1'b1;
         end
      end
   end

endmodule

// File: rtl/l2_wb_buffer.sv
// Write-back buffer between the L2 data array and memory: FIFO of evicted
// dirty lines, drained over valid/ready, with refill hazard detect and flush.
module l2_wb_buffer
   import l2_wb_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = L2_ADDR_W,
   parameter int DATA_W = L2_DATA_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      evict_valid,
   output logic                      evict_ready,
   input  logic [ADDR_W-1:0]         evict_addr,
   input  logic [DATA_W-1:0]         evict_data,
   output logic                      mem_wr_valid,
   input  logic                      mem_wr_ready,
   output logic [ADDR_W-1:0]         mem_wr_addr,
   output logic [DATA_W-1:0]         mem_wr_data,
   input  logic                      refill_req,
   input  logic [ADDR_W-1:0]         refill_addr,
   output logic                      refill_hazard,
   input  logic                      flush_req,
   output logic                      flush_done,
   output logic [$clog2(DEPTH):0]    wb_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic [DEPTH-1:0]        valid_q, valid_d;
   logic [DEPTH*ADDR_W-1:0] addr_mem_q, addr_mem_d;
   logic [DATA_W-1:0]       data_mem_q [DEPTH];
   logic [DATA_W-1:0]       data_mem_d [DEPTH];
   flush_state_e            state_q, state_d;
   logic                    done_seen_q, done_seen_d;
   logic                    enq, deq, cam_match;

   l2_wb_addr_cam #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_cam (
      .entry_addr  (addr_mem_q),
      .entry_valid (valid_q),
      .cmp_addr    (refill_addr),
      .match       (cam_match)
   );

   // Ready is based on the registered count only, so a full buffer stays
   // closed for the cycle in which its head drains.
   always_comb begin
      evict_ready   = (count_q < CNT_W'(DEPTH)) && (state_q == NORMAL);
      mem_wr_valid  = (count_q != '0);
      mem_wr_addr   = addr_mem_q[rd_ptr_q*ADDR_W +: ADDR_W];
      mem_wr_data   = data_mem_q[rd_ptr_q];
      enq           = evict_valid && evict_ready;
      deq           = mem_wr_valid && mem_wr_ready;
      refill_hazard = refill_req && (cam_match || (enq && (evict_addr == refill_addr)));
      flush_done    = (state_q == DONE) && !done_seen_q;
      wb_count      = count_q;
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      valid_d    = valid_q;
      addr_mem_d = addr_mem_q;
      data_mem_d = data_mem_q;
      if (deq) begin
         valid_d[rd_ptr_q] = 1'b0;
         rd_ptr_d          = rd_ptr_q + 1'b1;
      end
      if (enq) begin
         addr_mem_d[wr_ptr_q*ADDR_W +: ADDR_W] = evict_addr;
         data_mem_d[wr_ptr_q]                  = evict_data;
         valid_d[wr_ptr_q]                     = 1'b1;
         wr_ptr_d                              = wr_ptr_q + 1'b1;
      end
      case ({enq, deq})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // done_seen_q marks the wait phase of DONE, after the one-cycle pulse.
   always_comb begin
      state_d     = state_q;
      done_seen_d = (state_q == DONE);
      case (state_q)
         NORMAL: if (flush_req) state_d = (count_q == '0) ? DONE : FLUSH;
         FLUSH:  if (((count_q == CNT_W'(1)) && deq) || (count_q == '0)) state_d = DONE;
         DONE:   if (!flush_req) state_d = NORMAL;
         default: state_d = NORMAL;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         valid_q     <= '0;
         addr_mem_q  <= '0;
         // NOTE: line storage is reset as well, so an idle buffer presents zeros on mem_wr_*.
         for (int i = 0; i < DEPTH; i++) data_mem_q[i] <= '0;
         state_q     <= NORMAL;
         done_seen_q <= 1'b0;
      end else begin
         // NOTE: non-blocking updates keep every register sampling pre-edge values.
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         valid_q     <= valid_d;
         addr_mem_q  <= addr_mem_d;
         data_mem_q  <= data_mem_d;
         state_q     <= state_d;
         done_seen_q <= done_seen_d;
      end
   end

endmodule

// File: doc/l2_wb_buffer.md
Name: l2_wb_buffer

Overview:
- Write-back buffer between the L2 data array and main memory.
- Captures 512-bit dirty lines evicted from L2 (the array's write-to-memory data output plus line address) into a small FIFO.
- Drains entries to memory over a valid/ready handshake.
- Flags refill requests that hit a still-pending entry so the L2 controller stalls the refill until memory is coherent.
- Supports a flush command that drains the buffer completely.

Parameters:
- DEPTH, 4, number of line entries; power of two, >= 2.
- ADDR_W, 26, line address width (32-bit byte address, 64 B lines).
- DATA_W, 512, line width in bits.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- evict_valid  in  1  L2 presents a dirty line.
- evict_ready  out  1  buffer accepts the line this cycle.
- evict_addr  in  ADDR_W  line address of the evicted line.
- evict_data  in  DATA_W  evicted line data.
- mem_wr_valid  out  1  head entry valid toward memory.
- mem_wr_ready  in  1  memory accepts the head entry.
- mem_wr_addr  out  ADDR_W  head entry address.
- mem_wr_data  out  DATA_W  head entry data.
- refill_req  in  1  L2 is about to request a refill.
- refill_addr  in  ADDR_W  refill line address.
- refill_hazard  out  1  refill address matches a pending entry.
- flush_req  in  1  level request to drain the buffer.
- flush_done  out  1  one-cycle pulse when a flush completes.
- wb_count  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (asynchronous, rst=1):
  - Pointers, count and all storage are cleared to 0; FSM goes to NORMAL.
  - Resulting outputs: evict_ready=1, mem_wr_valid=0, mem_wr_addr=0, mem_wr_data=0, refill_hazard=0, flush_done=0, wb_count=0.
  - Reset asserted mid-transfer discards all entries; no partial line is retained.
- Storage:
  - Circular FIFO with wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping naturally modulo DEPTH.
  - Per-entry valid bits are kept for hazard compare.
- Enqueue:
  - Occurs when evict_valid && evict_ready.
  - Address and data are written at wr_ptr on the rising edge; wr_ptr increments.
- Enqueue-to-memory latency: a line accepted in cycle N appears on mem_wr_* in cycle N+1 at the earliest (no combinational bypass).
- evict_ready is 1 only when count < DEPTH and state == NORMAL. It is registered-count based: when full, a same-cycle dequeue does NOT open a slot until the next cycle.
- Dequeue:
  - Occurs when mem_wr_valid && mem_wr_ready; rd_ptr increments and the entry's valid bit clears.
  - mem_wr_valid = (count != 0).
  - mem_wr_addr/data are driven from the entry at rd_ptr and stay stable while valid && !ready.
  - When empty, mem_wr_addr/data still show the entry at rd_ptr, which is stale data; its value is don't-care.
- Simultaneous enqueue and dequeue: count unchanged; both pointers advance.
- wb_count:
  - Increments by 1 on enqueue-only.
  - Decrements by 1 on dequeue-only.
  - Never exceeds DEPTH and never underflows.
- refill_hazard (combinational) = refill_req AND (refill_addr matches any valid entry, OR evict_valid && evict_ready && evict_addr == refill_addr).
  - An entry being dequeued in the same cycle still counts as a match (conservative).
- Flush FSM:
  - NORMAL:
    - flush_req=1 and count==0 -> DONE.
    - flush_req=1 and count>0 -> FLUSH.
  - FLUSH:
    - No enqueues (evict_ready=0); draining continues.
    - When count==1 and a dequeue occurs, or count==0 -> DONE.
  - DONE:
    - flush_done=1 for exactly this cycle.
    - Next state NORMAL when flush_req=0; otherwise stay in DONE with flush_done=0 (wait state) until flush_req drops.
  - A flush_req deasserted during FLUSH does not abort the flush; draining completes.
- Duplicate addresses may coexist in the FIFO. Memory order equals eviction order, so the later entry wins.

Decomposition:
- Shared package holds:
  - L2 geometry constants: DATA_W=512, line offset 6 bits, ADDR_W.
  - Flush FSM state enum {NORMAL, FLUSH, DONE}.
- One sub-module: l2_wb_addr_cam, DEPTH-entry address compare returning a match bit. It is reused later by the L1-side buffer.

Test Plan:
1. Reset then idle -> evict_ready=1, mem_wr_valid=0, wb_count=0. Assert rst mid-drain with 3 entries -> all outputs return to reset values the same cycle.
2. Enqueue addr 0x0000A1 data {16{32'hDEADBEEF}} with mem_wr_ready=0 -> next cycle mem_wr_valid=1, addr 0x0000A1, data stable over 5 stall cycles. Raise ready -> wb_count returns to 0.
3. Enqueue 4 lines (0x10-0x13) with ready=0 -> evict_ready=0 and wb_count=4. Present a 5th line with ready=1 that cycle -> not accepted; accepted the following cycle. Drain order 0x10,0x11,0x12,0x13,5th; pointers wrap.
4. Continuous enqueue+dequeue every cycle for 20 lines -> wb_count holds at 1, in-order delivery, no drops.
5. Pending 0x55, refill_req with addr 0x55 -> refill_hazard=1. With addr 0x56 -> 0. Same-cycle enqueue of 0x77 with refill_addr 0x77 -> 1.
6. 3 entries, flush_req=1 -> evict_ready=0 immediately. flush_done pulses once in the cycle after the last dequeue; flush with empty buffer -> flush_done the next cycle.
